// File: rtl/cia_bus_capture.sv
// cia_bus_capture: CIA-side bus front end. Synchronises the asynchronous 68k/CIA
// bus into the clk domain and turns complete E-clock cycles into single-cycle
// read/write/timeout events for the controller register file.
// Optional E glitch filter: define CIA_BUS_E_FILTER_EN.
module cia_bus_capture #(
  parameter int DATA_WIDTH  = 8,
  parameter int REG_WIDTH   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  _reset,
  output logic                  rst,
  input  logic [REG_WIDTH-1:0]  reg_sel,
  input  logic                  r_w,
  input  logic                  _cs,
  input  logic                  e,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [REG_WIDTH-1:0]  reg_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_stb,
  output logic                  rd_req,
  output logic                  rd_done,
  output logic                  busy,
  output logic                  err_timeout
);

`ifdef CIA_BUS_E_FILTER_EN
  localparam int EXTRA_STAGES = 2;
`else
  localparam int EXTRA_STAGES = 0;
`endif
  localparam int CTRL_STAGES = SYNC_STAGES + EXTRA_STAGES;
  localparam int CW = REG_WIDTH + DATA_WIDTH + 2;
  localparam logic [CW-1:0] CTRL_RST = {{REG_WIDTH{1'b0}}, 1'b1, 1'b1, {DATA_WIDTH{1'b0}}};
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic {IDLE, SELECTED} state_t;

  logic [SYNC_STAGES-1:0] rst_pipe;
  logic [SYNC_STAGES-1:0] e_sync;
  logic [CW-1:0]          ctrl_sync [CTRL_STAGES];
  logic [REG_WIDTH-1:0]   reg_sel_s;
  logic [DATA_WIDTH-1:0]  data_s;
  logic                   r_w_s;
  logic                   cs_s;
  logic                   e_s;
  logic                   e_prev;
  logic                   e_cur;
  logic                   rise;
  logic                   fall;
  state_t                 state;
  logic                   dir_read;
  logic [7:0]             count;

  // Local reset: asserts with _reset, releases after SYNC_STAGES clean clk edges
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) rst_pipe <= '1;
    else         rst_pipe <= {rst_pipe[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst = rst_pipe[SYNC_STAGES-1];

  // E clock synchroniser chain
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) e_sync <= '0;
    else         e_sync <= {e_sync[SYNC_STAGES-2:0], e};
  end

  assign e_s = e_sync[SYNC_STAGES-1];

  // Control/data synchronisers, lengthened when the E filter adds latency
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      for (int i = 0; i < CTRL_STAGES; i++) ctrl_sync[i] <= CTRL_RST;
    end else begin
      ctrl_sync[0] <= {reg_sel, r_w, _cs, data};
      for (int i = 1; i < CTRL_STAGES; i++) ctrl_sync[i] <= ctrl_sync[i-1];
    end
  end

  assign {reg_sel_s, r_w_s, cs_s, data_s} = ctrl_sync[CTRL_STAGES-1];

`ifdef CIA_BUS_E_FILTER_EN
  logic e_h1;
  logic e_h2;

  // Filtered E only follows e_s once it has held steady for three samples
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      e_h1   <= 1'b0;
      e_h2   <= 1'b0;
      e_prev <= 1'b0;
    end else begin
      e_h1   <= e_s;
      e_h2   <= e_h1;
      e_prev <= e_cur;
    end
  end

  assign e_cur = (e_s == e_h1 && e_h1 == e_h2) ? e_s : e_prev;
`else
  // Delayed copy of e_s for edge detection
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) e_prev <= 1'b0;
    else         e_prev <= e_s;
  end

  assign e_cur = e_s;
`endif

  // Registered E edge flags
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= e_cur & ~e_prev;
      fall <= ~e_cur & e_prev;
    end
  end

  // Bus cycle decoder: abort beats completion, completion beats timeout
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state       <= IDLE;
      dir_read    <= 1'b0;
      count       <= '0;
      reg_addr    <= '0;
      wr_data     <= '0;
      wr_stb      <= 1'b0;
      rd_req      <= 1'b0;
      rd_done     <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else if (rst) begin
      state       <= IDLE;
      dir_read    <= 1'b0;
      count       <= '0;
      reg_addr    <= '0;
      wr_data     <= '0;
      wr_stb      <= 1'b0;
      rd_req      <= 1'b0;
      rd_done     <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      wr_stb      <= 1'b0;
      rd_req      <= 1'b0;
      rd_done     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (rise && !cs_s) begin
            reg_addr <= reg_sel_s;
            dir_read <= r_w_s;
            rd_req   <= r_w_s;
            count    <= '0;
            busy     <= 1'b1;
            state    <= SELECTED;
          end
        end
        SELECTED: begin
          if (count != 8'hFF) count <= count + 8'd1;
          if (cs_s) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (fall) begin
            if (dir_read) begin
              rd_done <= 1'b1;
            end else begin
              wr_data <= data_s;
              wr_stb  <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end else if (count == TIMEOUT_CNT) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cia_bus_capture.sv
// tb_cia_bus_capture: directed bench for cia_bus_capture (SYNC_STAGES=2, TIMEOUT=10).
// Expected strobes are queued with their due cycle when E is driven and are
// matched by the monitor when the DUT pulses them.
module tb_cia_bus_capture;

`ifdef CIA_BUS_E_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif
  localparam logic [3:0] K_WR = 4'b0001;
  localparam logic [3:0] K_RQ = 4'b0010;
  localparam logic [3:0] K_RD = 4'b0100;
  localparam logic [3:0] K_TO = 4'b1000;

  logic       clk = 1'b0;
  logic       _reset;
  logic       rst;
  logic [3:0] reg_sel;
  logic       r_w;
  logic       _cs;
  logic       e;
  logic [7:0] data;
  logic [3:0] reg_addr;
  logic [7:0] wr_data;
  logic       wr_stb;
  logic       rd_req;
  logic       rd_done;
  logic       busy;
  logic       err_timeout;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] cyc;
    logic [3:0]  addr;
    logic [7:0]  data;
  } ev_t;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  errors = 0;
  int  checks = 0;

  cia_bus_capture #(
    .DATA_WIDTH (8),
    .REG_WIDTH  (4),
    .SYNC_STAGES(2),
    .TIMEOUT    (10)
  ) dut (
    .clk        (clk),
    ._reset     (_reset),
    .rst        (rst),
    .reg_sel    (reg_sel),
    .r_w        (r_w),
    ._cs        (_cs),
    .e          (e),
    .data       (data),
    .reg_addr   (reg_addr),
    .wr_data    (wr_data),
    .wr_stb     (wr_stb),
    .rd_req     (rd_req),
    .rd_done    (rd_done),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected and observed events
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic cs_v, input logic rw_v, input logic [3:0] sel_v, input logic [7:0] data_v);
    @(negedge clk);
    _cs     = cs_v;
    r_w     = rw_v;
    reg_sel = sel_v;
    data    = data_v;
  endtask

  task automatic setE(input logic v);
    @(negedge clk);
    e = v;
  endtask

  task automatic expectEvent(input logic [3:0] k, input int delay, input logic [3:0] a, input logic [7:0] d);
    ev_t ev;
    ev.kind = k;
    ev.cyc  = 32'(cyc + delay);
    ev.addr = a;
    ev.data = d;
    exp_q.push_back(ev);
  endtask

  task automatic checkResetOutputs(input string prefix);
    checkOutput({prefix, "_rst"}, rst, 1);
    checkOutput({prefix, "_busy"}, busy, 0);
    checkOutput({prefix, "_reg_addr"}, reg_addr, 0);
    checkOutput({prefix, "_wr_data"}, wr_data, 0);
    checkOutput({prefix, "_strobes"}, {wr_stb, rd_req, rd_done, err_timeout}, 0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin : monitor
    logic [3:0] kind;
    ev_t        ev;
    kind = {err_timeout, rd_done, rd_req, wr_stb};
    if (kind != 4'b0000) begin
      checkOutput("event_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        checkOutput("event_kind", kind, ev.kind);
        checkOutput("event_cycle", cyc, ev.cyc);
        checkOutput("event_reg_addr", reg_addr, ev.addr);
        if (ev.kind == K_WR) checkOutput("event_wr_data", wr_data, ev.data);
      end
    end
  end

  // Directed stimulus sequence
  initial begin
    _reset  = 1'b0;
    e       = 1'b0;
    _cs     = 1'b1;
    r_w     = 1'b1;
    reg_sel = 4'h0;
    data    = 8'h00;

    waitCycles(2);
    checkResetOutputs("init");
    _reset = 1'b1;
    waitCycles(1);
    checkOutput("rst_hold_1", rst, 1);
    waitCycles(1);
    checkOutput("rst_release_2", rst, 0);
    waitCycles(3);

    // Write cycle
    applyStimulus(1'b0, 1'b0, 4'hD, 8'hA5);
    waitCycles(4);
    setE(1'b1);
    waitCycles(LAT + 2);
    checkOutput("write_busy", busy, 1);
    setE(1'b0);
    expectEvent(K_WR, LAT, 4'hD, 8'hA5);
    waitCycles(LAT + 4);
    checkOutput("write_busy_done", busy, 0);
    checkOutput("write_reg_addr", reg_addr, 4'hD);
    checkOutput("write_wr_data", wr_data, 8'hA5);

    // Read cycle
    applyStimulus(1'b0, 1'b1, 4'h3, 8'h5A);
    waitCycles(4);
    setE(1'b1);
    expectEvent(K_RQ, LAT, 4'h3, 8'h00);
    waitCycles(LAT + 2);
    setE(1'b0);
    expectEvent(K_RD, LAT, 4'h3, 8'h00);
    waitCycles(LAT + 4);
    checkOutput("read_wr_data_kept", wr_data, 8'hA5);

    // Abort: _cs raised while E is high
    applyStimulus(1'b0, 1'b0, 4'h7, 8'h11);
    waitCycles(4);
    setE(1'b1);
    waitCycles(LAT + 2);
    checkOutput("abort_busy", busy, 1);
    _cs = 1'b1;
    waitCycles(8);
    checkOutput("abort_busy_drop", busy, 0);
    e = 1'b0;
    waitCycles(LAT + 4);
    checkOutput("abort_wr_data_kept", wr_data, 8'hA5);

    // Abort and E fall in the same cycle: abort wins
    applyStimulus(1'b0, 1'b0, 4'h6, 8'h22);
    waitCycles(4);
    setE(1'b1);
    waitCycles(LAT + 2);
    @(negedge clk);
    e   = 1'b0;
    _cs = 1'b1;
    waitCycles(LAT + 4);
    checkOutput("abort_fall_busy", busy, 0);
    checkOutput("abort_fall_wr_data", wr_data, 8'hA5);

    // Next valid cycle after aborts decodes normally
    applyStimulus(1'b0, 1'b0, 4'h9, 8'h3C);
    waitCycles(4);
    setE(1'b1);
    waitCycles(LAT + 2);
    setE(1'b0);
    expectEvent(K_WR, LAT, 4'h9, 8'h3C);
    waitCycles(LAT + 4);
    checkOutput("post_abort_wr_data", wr_data, 8'h3C);

    // Timeout: E held high, read direction
    applyStimulus(1'b0, 1'b1, 4'hB, 8'h00);
    waitCycles(4);
    setE(1'b1);
    expectEvent(K_RQ, LAT, 4'hB, 8'h00);
    expectEvent(K_TO, LAT + 11, 4'hB, 8'h00);
    waitCycles(LAT + 10);
    checkOutput("timeout_busy_before", busy, 1);
    waitCycles(6);
    checkOutput("timeout_busy_after", busy, 0);
    setE(1'b0);
    waitCycles(LAT + 4);

    // Reset in the middle of a write cycle
    applyStimulus(1'b0, 1'b0, 4'h5, 8'h77);
    waitCycles(4);
    setE(1'b1);
    waitCycles(LAT + 2);
    checkOutput("midreset_busy", busy, 1);
    @(negedge clk);
    _reset = 1'b0;
    #1;
    checkResetOutputs("midreset");
    e = 1'b0;
    waitCycles(3);
    _reset = 1'b1;
    waitCycles(1);
    checkOutput("midreset_rst_1", rst, 1);
    waitCycles(1);
    checkOutput("midreset_rst_2", rst, 0);
    waitCycles(LAT + 4);
    checkOutput("midreset_busy_after", busy, 0);

`ifdef CIA_BUS_E_FILTER_EN
    // Two-cycle E glitch is rejected by the filter
    applyStimulus(1'b0, 1'b1, 4'h2, 8'h00);
    waitCycles(4);
    setE(1'b1);
    waitCycles(1);
    setE(1'b0);
    waitCycles(10);
    checkOutput("glitch_busy", busy, 0);
`endif

    // Final read cycle after reset
    applyStimulus(1'b0, 1'b1, 4'hE, 8'h00);
    waitCycles(4);
    setE(1'b1);
    expectEvent(K_RQ, LAT, 4'hE, 8'h00);
    waitCycles(LAT + 2);
    setE(1'b0);
    expectEvent(K_RD, LAT, 4'hE, 8'h00);
    waitCycles(LAT + 6);

    checkOutput("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cia_bus_capture.md
# cia_bus_capture

Parametrised CIA-side bus front end: synchronises the asynchronous 68k/CIA bus (E clock, chip select, R/_W, register select, data) into the local clock domain and decodes complete E-clock bus cycles into single-cycle read/write events. It sits between the Amiga expansion pins and the controller register file. It replaces bare per-signal synchronisation with configurable widths and stage counts, cycle decoding, abort handling and timeout detection.

## Interface

Parameters:
- DATA_WIDTH, 8, data bus width in bits.
- REG_WIDTH, 4, register-select width in bits.
- SYNC_STAGES, 2, flip-flops per synchroniser chain; legal range 2..4.
- TIMEOUT, 255, maximum clk cycles in SELECTED before abort; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  destination clock.
- _reset  in  1  asynchronous, active-low reset.
- rst  out  1  local reset, active-high; asserts asynchronously, deasserts synchronously after SYNC_STAGES clk edges.
- reg_sel  in  REG_WIDTH  register select (asynchronous).
- r_w  in  1  R/_W (asynchronous).
- _cs  in  1  chip select, active-low (asynchronous).
- e  in  1  E clock (asynchronous).
- data  in  DATA_WIDTH  data bus (asynchronous).
- reg_addr  out  REG_WIDTH  register index latched at cycle start.
- wr_data  out  DATA_WIDTH  write data latched at the E falling edge.
- wr_stb  out  1  one-cycle pulse: write cycle completed.
- rd_req  out  1  one-cycle pulse: read cycle started; reg_addr is valid.
- rd_done  out  1  one-cycle pulse: read cycle completed.
- busy  out  1  high while in SELECTED.
- err_timeout  out  1  one-cycle pulse: SELECTED exceeded TIMEOUT.

## Operation

- Every input bit has its own SYNC_STAGES-deep chain. Reset values: _cs=1, r_w=1, e=0, reg_sel=0, data=0. Suffix _s denotes the synchronised value; e_d is e_s delayed one cycle.
- Edge detection: rise = e_s & ~e_d; fall = ~e_s & e_d.
- State IDLE:
  - On rise with _cs_s=0: latch reg_addr<=reg_sel_s and the cycle direction <=r_w_s, clear the counter, and go to SELECTED.
  - If r_w_s=1, pulse rd_req in the same transition.
  - A rise with _cs_s=1 is ignored.
- State SELECTED:
  - busy=1; the counter increments every cycle and saturates at 255.
  - Priority order:
    - (1) _cs_s=1: abort to IDLE with no strobes.
    - (2) fall: for a write, latch wr_data<=data_s and pulse wr_stb; for a read, pulse rd_done. Then go to IDLE.
    - (3) counter==TIMEOUT: pulse err_timeout and go to IDLE.
- fall and _cs_s=1 in the same cycle resolve as abort.
- A rise in the cycle that leaves SELECTED is not observed. A new cycle needs a fresh rise.
- Reset, including mid-cycle: all flops return to reset values and the state returns to IDLE.
- Output reset values: rst=1, reg_addr=0, wr_data=0, wr_stb=0, rd_req=0, rd_done=0, busy=0, err_timeout=0.
- All strobes and outputs are registered and are masked while rst=1.

## Timing

- Pin-to-_s latency: SYNC_STAGES clk cycles. rise and fall are detected 1 cycle after e_s changes.
- rd_req and wr_stb/rd_done assert 1 cycle after rise/fall detection. Total from a pin edge: SYNC_STAGES+2 clk cycles (+2 with the filter enabled).
- reg_addr is stable from rd_req until the next cycle start.
- wr_data is stable from wr_stb until the next write.
- Consecutive E cycles are handled back-to-back, provided E high and E low are each at least 3 clk periods long.

## Configuration

- CIA_BUS_E_FILTER_EN defined: e_s must hold the same value for 3 consecutive clk cycles before the filtered value changes. rise and fall are derived from the filtered value, which rejects E glitches of 1–2 cycles and adds 2 cycles of latency. Data and control are delayed by 2 extra stages so they stay aligned with the filtered E.
- Not defined: rise and fall are taken directly from e_s.

## Test plan

- Write cycle: with SYNC_STAGES=2, drive _cs=0, r_w=0, reg_sel=4'hD, data=8'hA5, then toggle E. Expect exactly one wr_stb with reg_addr=4'hD and wr_data=8'hA5, arriving 4 cycles after the E falling edge; no rd_req.
- Read cycle: drive reg_sel=4'h3, r_w=1. Expect rd_req 4 cycles after E rises with reg_addr=4'h3, then one rd_done 4 cycles after E falls; no wr_stb.
- Abort: raise _cs while E is high. Expect busy to drop, no wr_stb/rd_done, and the next valid cycle to decode normally.
- Timeout: set TIMEOUT=10 and hold E high with _cs=0. Expect err_timeout 11 cycles after busy rises, busy=0 afterwards, and a later E fall producing no strobe.
- Reset mid-cycle: pulse _reset low while in SELECTED. Expect all outputs at their reset values immediately, rst deasserting 2 cycles after _reset rises, and no strobe from the pending cycle.
- Filter: with CIA_BUS_E_FILTER_EN defined, apply a 2-cycle E-high glitch with _cs=0. Expect no rd_req/busy. A 5-cycle E-high pulse decodes normally with +2 cycles of latency.
